// File: rtl/rx_sampler.sv
// rx_sampler
//   Oversampling front end of the UART receiver. Counts prescaled clock
//   edges within each bit period, tracks the bit index inside the frame,
//   and resolves three mid-bit samples of the serial line into one bit per
//   bit period by majority vote.
//
//   Optional build macro:
//     RX_SAMPLER_SYNC_EN - RX_IN passes through a two-flop synchronizer
//                          (preset to 1 on Reset) before sampling.
//
//   Ports:
//     CLK          in   receiver clock (Prescale x baud)
//     Reset        in   synchronous, active-high reset
//     RX_IN        in   serial line, idle high
//     Prescale     in   oversampling ratio; 16 or 32, anything else acts as 8
//     sample_EN    in   high for the duration of a frame
//     edge_cnt     out  edge index within the current bit, 0..P-1
//     bit_cnt      out  bit index within the frame, start bit = 0
//     bit_done     out  combinational pulse on the last edge of each bit
//     sampled_bit  out  majority-voted bit value
//     sample_valid out  one-cycle strobe, sampled_bit just updated
module rx_sampler #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  sample_EN,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic                  rx_s;
    logic                  s0;
    logic                  s1;

    // Only 16 and 32 are honoured; every other code falls back to 8.
    always_comb begin
        p_eff = PRESCALE_W'(8);
        if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32)) begin
            p_eff = Prescale;
        end
        half      = p_eff >> 1;
        last_edge = p_eff - PRESCALE_W'(1);
    end

`ifdef RX_SAMPLER_SYNC_EN
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_sync <= rx_meta;
        end
    end

    assign rx_s = rx_sync;
`else
    assign rx_s = RX_IN;
`endif

    assign bit_done = sample_EN & (edge_cnt == last_edge);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            s0           <= 1'b1;
            s1           <= 1'b1;
        end else if (!sample_EN) begin
            // Partial samples in s0/s1 are simply abandoned; they are
            // overwritten before the next vote can use them.
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            sample_valid <= 1'b0;
        end else begin
            if (edge_cnt == last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (edge_cnt == half - PRESCALE_W'(1)) begin
                s0 <= rx_s;
            end
            if (edge_cnt == half) begin
                s1 <= rx_s;
            end

            // Third sample is the live line value; vote happens here.
            sample_valid <= (edge_cnt == half + PRESCALE_W'(1));
            if (edge_cnt == half + PRESCALE_W'(1)) begin
                sampled_bit <= (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
            end
        end
    end

endmodule

// File: tb/tb_rx_sampler.sv
module tb_rx_sampler;

    localparam int PW = 6;
    localparam int BW = 4;
`ifdef RX_SAMPLER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic          CLK = 1'b0;
    logic          Reset;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          sample_EN;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          bit_done;
    logic          sampled_bit;
    logic          sample_valid;

    always #5 CLK = ~CLK;

    rx_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .sample_EN    (sample_EN),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is just a run of consecutive enabled cycles.
    // Edge/bit indices follow from the run length; samples come from the
    // recorded line history.
    bit raw_h [0:16383];
    bit rst_h [0:16383];
    int cyc   = 0;
    int m_run = 0;
    int m_pe  = 8;
    bit m_sb  = 1'b1;
    bit m_sv  = 1'b0;
    bit m_ok  = 1'b0;

    function automatic int peff(input int p);
        return (p == 16 || p == 32) ? p : 8;
    endfunction

    // Line value seen by the sampling logic at cycle c.
    function automatic int eff(input int c);
`ifdef RX_SAMPLER_SYNC_EN
        if (c < 2) return 1;
        if (rst_h[c-1] || rst_h[c-2]) return 1;
        return int'(raw_h[c-2]);
`else
        return int'(raw_h[c]);
`endif
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit x, input int p);
        Reset     = r;
        sample_EN = e;
        RX_IN     = x;
        Prescale  = PW'(p);
        #1;
    endtask

    task automatic model_check;
        int pe;
        int e;
        if (!m_ok) return;
        pe = peff(int'(Prescale));
        e  = m_run % m_pe;
        chk("m_edge", edge_cnt, e);
        chk("m_bit", bit_cnt, (m_run / m_pe) % 16);
        chk("m_done", bit_done, (sample_EN && e == pe - 1) ? 1 : 0);
        chk("m_sb", sampled_bit, m_sb);
        chk("m_sv", sample_valid, m_sv);
    endtask

    task automatic advance;
        raw_h[cyc] = RX_IN;
        rst_h[cyc] = Reset;
        if (Reset) begin
            m_run = 0;
            m_sb  = 1'b1;
            m_sv  = 1'b0;
            m_ok  = 1'b1;
        end else if (!sample_EN) begin
            m_run = 0;
            m_sv  = 1'b0;
        end else begin
            if (m_run == 0) m_pe = peff(int'(Prescale));
            m_sv = ((m_run % m_pe) == m_pe / 2 + 1);
            if (m_sv) m_sb = (eff(cyc - 2) + eff(cyc - 1) + eff(cyc)) >= 2;
            m_run++;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic step(input bit r, input bit e, input bit x, input int p);
        drive(r, e, x, p);
        model_check();
        advance();
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit rx;
        bit chk;
        int e_edge;
        int e_bit;
        bit e_done;
        bit e_sb;
        bit e_sv;
    } vec_t;

    vec_t tv [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int nsv;
        int maxe;
        bit rx;
        bit r;
        bit e;
        bit wrap_next;
        int pc [6];

        // Reset then the first P=8 bit, cycle by cycle.
        tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
        tv[1]  = '{1, 1, 0, 1, 0, 0, 0, 1, 0};
        tv[2]  = '{0, 1, 0, 1, 0, 0, 0, 1, 0};
        tv[3]  = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
        tv[4]  = '{0, 1, 0, 1, 2, 0, 0, 1, 0};
        tv[5]  = '{0, 1, 0, 1, 3, 0, 0, 1, 0};
        tv[6]  = '{0, 1, 0, 1, 4, 0, 0, 1, 0};
        tv[7]  = '{0, 1, 0, 1, 5, 0, 0, 1, 0};
        tv[8]  = '{0, 1, 0, 1, 6, 0, 0, 0, 1};
        tv[9]  = '{0, 1, 0, 1, 7, 0, 1, 0, 0};
        tv[10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
        tv[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        tv[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].rx, 8);
            if (tv[i].chk) begin
                chk("tv_edge", edge_cnt, tv[i].e_edge);
                chk("tv_bit", bit_cnt, tv[i].e_bit);
                chk("tv_done", bit_done, tv[i].e_done);
                chk("tv_sb", sampled_bit, tv[i].e_sb);
                chk("tv_sv", sample_valid, tv[i].e_sv);
            end
            advance();
        end

        // P=8, 80 enabled cycles, line toggles every bit.
        step(0, 0, 1, 8);
        nd  = 0;
        nsv = 0;
        for (int k = 0; k < 80; k++) begin
            drive(0, 1, bit'((k / 8) % 2), 8);
            model_check();
            if (bit_done) nd++;
            if (sample_valid) begin
                chk("tog_sv_edge", edge_cnt, 6);
                chk("tog_sb", sampled_bit, nsv % 2);
                nsv++;
            end
            advance();
        end
        drive(0, 0, 1, 8);
        model_check();
        chk("tog_bit_cnt", bit_cnt, 10);
        chk("tog_done_count", nd, 10);
        chk("tog_sv_count", nsv, 10);
        advance();

        // Glitch rejection at P=16: all-zero bit, one-cycle dip, two-cycle dip.
        step(0, 0, 1, 16);
        for (int k = 0; k < 48; k++) begin
            int b;
            int ed;
            b  = k / 16;
            ed = k % 16;
            if (b == 0)      rx = 1'b0;
            else if (b == 1) rx = (ed == 8 + D) ? 1'b0 : 1'b1;
            else             rx = (ed == 7 + D || ed == 8 + D) ? 1'b0 : 1'b1;
            drive(0, 1, rx, 16);
            model_check();
            if (ed == 12) begin
                if (b == 0)      chk("glitch_base", sampled_bit, 0);
                else if (b == 1) chk("glitch_single", sampled_bit, 1);
                else             chk("glitch_double", sampled_bit, 0);
            end
            advance();
        end

        // Illegal Prescale=12 behaves as 8.
        step(0, 0, 1, 12);
        maxe = 0;
        nsv  = 0;
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 1, 12);
            model_check();
            if (int'(edge_cnt) > maxe) maxe = int'(edge_cnt);
            if (sample_valid) begin
                chk("p12_sv_edge", edge_cnt, 6);
                nsv++;
            end
            advance();
        end
        chk("p12_max_edge", maxe, 7);
        chk("p12_sv_count", nsv, 2);

        // Abort at P=32: one full zero bit, then drop enable at edge_cnt=10.
        step(0, 0, 1, 32);
        for (int k = 0; k < 42; k++) step(0, 1, (k < 32) ? 1'b0 : 1'b1, 32);
        drive(0, 0, 1, 32);
        model_check();
        chk("abort_edge_at_drop", edge_cnt, 10);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 32);
            model_check();
            chk("abort_edge", edge_cnt, 0);
            chk("abort_bit", bit_cnt, 0);
            chk("abort_sv", sample_valid, 0);
            chk("abort_sb", sampled_bit, 0);
            advance();
        end

        // bit_cnt wrap at P=8 over 17 bits.
        step(0, 0, 1, 8);
        nd        = 0;
        wrap_next = 1'b0;
        for (int k = 0; k < 136; k++) begin
            drive(0, 1, 1, 8);
            model_check();
            if (wrap_next) begin
                chk("wrap_after", bit_cnt, 0);
                wrap_next = 1'b0;
            end
            if (bit_done) begin
                nd++;
                if (nd == 16) begin
                    chk("wrap_before", bit_cnt, 15);
                    wrap_next = 1'b1;
                end
            end
            advance();
        end
        chk("wrap_done_count", nd, 17);

        // Mid-frame reset.
        for (int k = 0; k < 5; k++) step(0, 1, 0, 8);
        step(1, 1, 0, 8);
        drive(0, 1, 0, 8);
        model_check();
        chk("rst_mid_edge", edge_cnt, 0);
        chk("rst_mid_sb", sampled_bit, 1);
        advance();

        // Randomized segments against the model.
        pc = '{8, 16, 32, 12, 0, 63};
        rx = 1'b1;
        for (int s = 0; s < 20; s++) begin
            int p;
            int len;
            p   = pc[$urandom_range(0, 5)];
            len = $urandom_range(40, 120);
            step(0, 0, rx, p);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0) rx = ~rx;
                r = ($urandom_range(0, 299) == 0);
                e = ($urandom_range(0, 24) != 0);
                step(r, e, rx, p);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
